// File: rtl/layer_apb_sched_if.sv
// Command, status and shared APB signals of the layer scheduler.
// master = scheduler side, slave = host/layer-unit side.
interface layer_apb_sched_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_data;
  logic        clear_err;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        penable;
  logic        psel_fc;
  logic        psel_conv;
  logic        psel_pool;
  logic [31:0] prdata_fc;
  logic [31:0] prdata_conv;
  logic [31:0] prdata_pool;
  logic        pready_fc;
  logic        pready_conv;
  logic        pready_pool;
  logic        pslverr_fc;
  logic        pslverr_conv;
  logic        pslverr_pool;

  modport master (
    input  cmd_valid, cmd_data, clear_err,
    input  prdata_fc, prdata_conv, prdata_pool,
    input  pready_fc, pready_conv, pready_pool,
    input  pslverr_fc, pslverr_conv, pslverr_pool,
    output cmd_ready, busy, done, err, err_code,
    output paddr, pwrite, pwdata, penable, psel_fc, psel_conv, psel_pool
  );

  modport slave (
    output cmd_valid, cmd_data, clear_err,
    output prdata_fc, prdata_conv, prdata_pool,
    output pready_fc, pready_conv, pready_pool,
    output pslverr_fc, pslverr_conv, pslverr_pool,
    input  cmd_ready, busy, done, err, err_code,
    input  paddr, pwrite, pwdata, penable, psel_fc, psel_conv, psel_pool
  );
endinterface

// File: rtl/layer_apb_sched.sv
// Command-driven APB master sequencing register writes and status polls
// to the FC, Conv and Pool layer units over one shared APB bus.
//
// state     | meaning
// IDLE      | accepting commands (ready one cycle after arrival)
// SETUP     | APB setup phase, PSEL of latched unit high
// ACCESS    | APB access phase, waiting for PREADY
// POLL_WAIT | gap between status reads of a POLL
// ERROR     | halted until CLEAR_ERR
module layer_apb_sched #(
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 65535
) (
  input logic               i_clk,
  input logic               i_resetn,
  layer_apb_sched_if.master bus
);
  localparam logic [1:0] OP_WRITE  = 2'd0;
  localparam logic [1:0] OP_POLL   = 2'd1;
  localparam logic [1:0] OP_END    = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;
  localparam logic [1:0] U_FC      = 2'd0;
  localparam logic [1:0] U_CONV    = 2'd1;
  localparam logic [1:0] U_POOL    = 2'd2;
  localparam logic [1:0] U_RSVD    = 2'd3;
  localparam logic [1:0] E_SLVERR  = 2'd1;
  localparam logic [1:0] E_TIMEOUT = 2'd2;
  localparam logic [1:0] E_ILLEGAL = 2'd3;
  localparam logic [15:0] GAP_LAST  = 16'(POLL_GAP - 1);
  localparam logic [16:0] TMO_LIMIT = 17'(POLL_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_POLL_WAIT, S_ERROR
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [1:0]  r_unit;
  logic [31:0] r_mask;
  logic [15:0] r_tmo;
  logic [15:0] r_gap;
  logic        r_cmd_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic        r_pwrite;
  logic        r_penable;
  logic        r_psel_fc;
  logic        r_psel_conv;
  logic        r_psel_pool;

  logic [1:0]  w_op;
  logic [1:0]  w_unit;
  logic        w_accept;
  logic [31:0] w_prdata;
  logic        w_pready;
  logic        w_pslverr;
  logic        w_in_xfer;
  logic [16:0] w_tmo_next;
  logic        w_tmo_hit;
  logic        w_poll_hit;

  assign w_op     = bus.cmd_data[47:46];
  assign w_unit   = bus.cmd_data[45:44];
  assign w_accept = bus.cmd_valid & r_cmd_ready;

  // Only the latched unit's response is observed.
  always_comb begin
    w_prdata  = '0;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    case (r_unit)
      U_FC:   begin w_prdata = bus.prdata_fc;   w_pready = bus.pready_fc;   w_pslverr = bus.pslverr_fc;   end
      U_CONV: begin w_prdata = bus.prdata_conv; w_pready = bus.pready_conv; w_pslverr = bus.pslverr_conv; end
      U_POOL: begin w_prdata = bus.prdata_pool; w_pready = bus.pready_pool; w_pslverr = bus.pslverr_pool; end
      default: ;
    endcase
  end

  assign w_in_xfer  = (r_state == S_SETUP) || (r_state == S_ACCESS) || (r_state == S_POLL_WAIT);
  assign w_tmo_next = {1'b0, r_tmo} + 17'd1;
  assign w_tmo_hit  = w_in_xfer && (r_op == OP_POLL) && (w_tmo_next == TMO_LIMIT);
  assign w_poll_hit = |(w_prdata & r_mask);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_unit      <= '0;
      r_mask      <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= '0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_penable   <= 1'b0;
      r_psel_fc   <= 1'b0;
      r_psel_conv <= 1'b0;
      r_psel_pool <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_xfer && (r_op == OP_POLL)) r_tmo <= w_tmo_next[15:0];
      // Timeout wins over a PREADY arriving in the same cycle.
      if (w_tmo_hit) begin
        r_state     <= S_ERROR;
        r_err       <= 1'b1;
        r_err_code  <= E_TIMEOUT;
        r_penable   <= 1'b0;
        r_psel_fc   <= 1'b0;
        r_psel_conv <= 1'b0;
        r_psel_pool <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            if (w_accept) begin
              if (w_op == OP_END) begin
                r_done <= 1'b1;
              end else if ((w_op == OP_RSVD) || (w_unit == U_RSVD)) begin
                r_state     <= S_ERROR;
                r_err       <= 1'b1;
                r_err_code  <= E_ILLEGAL;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
              end else begin
                r_state     <= S_SETUP;
                r_op        <= w_op;
                r_unit      <= w_unit;
                r_mask      <= bus.cmd_data[31:0];
                r_tmo       <= '0;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_paddr     <= {20'b0, bus.cmd_data[43:32]};
                r_pwrite    <= (w_op == OP_WRITE);
                r_pwdata    <= (w_op == OP_WRITE) ? bus.cmd_data[31:0] : 32'd0;
                r_penable   <= 1'b0;
                r_psel_fc   <= (w_unit == U_FC);
                r_psel_conv <= (w_unit == U_CONV);
                r_psel_pool <= (w_unit == U_POOL);
              end
            end
          end
          S_SETUP: begin
            r_state   <= S_ACCESS;
            r_penable <= 1'b1;
          end
          S_ACCESS: begin
            if (w_pready) begin
              r_penable   <= 1'b0;
              r_psel_fc   <= 1'b0;
              r_psel_conv <= 1'b0;
              r_psel_pool <= 1'b0;
              if (w_pslverr) begin
                r_state    <= S_ERROR;
                r_err      <= 1'b1;
                r_err_code <= E_SLVERR;
              end else if ((r_op == OP_WRITE) || w_poll_hit) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_POLL_WAIT;
                r_gap   <= '0;
              end
            end
          end
          S_POLL_WAIT: begin
            if (r_gap == GAP_LAST) begin
              r_state     <= S_SETUP;
              r_psel_fc   <= (r_unit == U_FC);
              r_psel_conv <= (r_unit == U_CONV);
              r_psel_pool <= (r_unit == U_POOL);
            end else begin
              r_gap <= r_gap + 16'd1;
            end
          end
          S_ERROR: begin
            if (bus.clear_err) begin
              r_state    <= S_IDLE;
              r_err      <= 1'b0;
              r_err_code <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_err_code;
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.penable   = r_penable;
  assign bus.psel_fc   = r_psel_fc;
  assign bus.psel_conv = r_psel_conv;
  assign bus.psel_pool = r_psel_pool;
endmodule

// File: tb/tb_layer_apb_sched.sv
// Bench for layer_apb_sched: directed commands, a scripted APB slave per unit,
// and a scoreboard of expected bus events checked by an independent monitor.
module tb_layer_apb_sched;
  localparam int GAP = 4;
  localparam int TMO = 50;

  localparam logic [2:0] K_WR   = 3'd1;
  localparam logic [2:0] K_RD   = 3'd2;
  localparam logic [2:0] K_DONE = 3'd3;
  localparam logic [2:0] K_ERR  = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  unit;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  code;
  } ev_t;

  logic i_clk = 1'b0;
  logic i_resetn = 1'b0;
  always #5 i_clk = ~i_clk;

  layer_apb_sched_if bus();

  layer_apb_sched #(.POLL_GAP(GAP), .POLL_TIMEOUT(TMO)) u_dut (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int g_done_cnt = 0;
  ev_t q_exp[$];

  int          g_wait = 0;
  logic        g_err = 1'b0;
  int          g_hit_read = 0;
  logic [31:0] g_hit_val = '0;
  int          s_read_idx = 0;
  int          s_wait_cnt = 0;
  logic        prev_err = 1'b0;

  function automatic ev_t mk(input logic [2:0] k, input logic [1:0] u, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] c);
    ev_t e;
    e.kind = k; e.unit = u; e.addr = a; e.data = d; e.code = c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input ev_t a);
    ev_t e;
    n_checks++;
    if (q_exp.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: got kind=%0d unit=%0d addr=%h data=%h code=%0d, expected none",
               a.kind, a.unit, a.addr, a.data, a.code);
    end else begin
      e = q_exp.pop_front();
      if (a !== e) begin
        n_errors++;
        $display("FAIL sb_event: got kind=%0d unit=%0d addr=%h data=%h code=%0d, expected kind=%0d unit=%0d addr=%h data=%h code=%0d",
                 a.kind, a.unit, a.addr, a.data, a.code, e.kind, e.unit, e.addr, e.data, e.code);
      end
    end
  endtask

  // Scripted slaves: the selected unit answers after g_wait wait states; unselected
  // units present junk (PREADY=1, PSLVERR=1) so a wrong response mux shows up.
  initial begin
    logic [2:0]  s_sel;
    logic        s_ready;
    logic [31:0] s_resp;
    bus.pready_fc = 1'b1; bus.pready_conv = 1'b1; bus.pready_pool = 1'b1;
    bus.pslverr_fc = 1'b1; bus.pslverr_conv = 1'b1; bus.pslverr_pool = 1'b1;
    bus.prdata_fc = '1; bus.prdata_conv = '1; bus.prdata_pool = '1;
    forever begin
      @(posedge i_clk); #1;
      s_sel   = {bus.psel_pool, bus.psel_conv, bus.psel_fc};
      s_ready = 1'b0;
      s_resp  = 32'hFFFF_FFFF;
      if ((s_sel != 3'b000) && bus.penable) begin
        if (s_wait_cnt < g_wait) begin
          s_wait_cnt++;
        end else begin
          s_ready    = 1'b1;
          s_wait_cnt = 0;
          s_resp     = 32'd0;
          if (!bus.pwrite) begin
            s_read_idx++;
            if ((g_hit_read != 0) && (s_read_idx >= g_hit_read)) s_resp = g_hit_val;
          end
        end
      end else begin
        s_wait_cnt = 0;
      end
      bus.pready_fc    = s_sel[0] ? s_ready : 1'b1;
      bus.pslverr_fc   = s_sel[0] ? (s_ready & g_err) : 1'b1;
      bus.prdata_fc    = s_sel[0] ? s_resp : 32'hFFFF_FFFF;
      bus.pready_conv  = s_sel[1] ? s_ready : 1'b1;
      bus.pslverr_conv = s_sel[1] ? (s_ready & g_err) : 1'b1;
      bus.prdata_conv  = s_sel[1] ? s_resp : 32'hFFFF_FFFF;
      bus.pready_pool  = s_sel[2] ? s_ready : 1'b1;
      bus.pslverr_pool = s_sel[2] ? (s_ready & g_err) : 1'b1;
      bus.prdata_pool  = s_sel[2] ? s_resp : 32'hFFFF_FFFF;
    end
  end

  // Monitor: turns completed APB transfers, DONE pulses and ERR entries into events.
  initial begin
    logic       m_rdy;
    logic       m_slv;
    logic [1:0] m_unit;
    forever begin
      @(posedge i_clk); #2;
      if (i_resetn) begin
        m_rdy  = (bus.psel_fc & bus.pready_fc) | (bus.psel_conv & bus.pready_conv) |
                 (bus.psel_pool & bus.pready_pool);
        m_slv  = (bus.psel_fc & bus.pslverr_fc) | (bus.psel_conv & bus.pslverr_conv) |
                 (bus.psel_pool & bus.pslverr_pool);
        m_unit = bus.psel_conv ? 2'd1 : (bus.psel_pool ? 2'd2 : 2'd0);
        if (bus.penable && m_rdy)
          sb_check(mk(bus.pwrite ? K_WR : K_RD, m_unit, bus.paddr, bus.pwdata, {1'b0, m_slv}));
        if (bus.done) begin
          g_done_cnt++;
          sb_check(mk(K_DONE, 2'd0, 32'd0, 32'd0, 2'd0));
        end
        if (bus.err && !prev_err) sb_check(mk(K_ERR, 2'd0, 32'd0, 32'd0, bus.err_code));
      end
      prev_err = bus.err;
    end
  end

  task automatic send_cmd(input logic [47:0] c);
    int n = 0;
    @(negedge i_clk);
    bus.cmd_data  = c;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && (n < 200)) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_cmd: cmd_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge i_clk);
  endtask

  task automatic drop_valid();
    @(negedge i_clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge i_clk);
    while (!bus.cmd_ready && (n < 200)) begin
      @(negedge i_clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      n_checks++; n_errors++;
      $display("FAIL %s: cmd_ready still 0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic pulse_clear();
    @(negedge i_clk);
    bus.clear_err = 1'b1;
    @(negedge i_clk);
    bus.clear_err = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 32'({bus.cmd_ready, bus.busy, bus.done, bus.err, bus.err_code, bus.penable,
                             bus.pwrite, bus.psel_fc, bus.psel_conv, bus.psel_pool}), 32'd0);
    chk({name, "_paddr"}, bus.paddr, 32'd0);
    chk({name, "_pwdata"}, bus.pwdata, 32'd0);
  endtask

  initial begin
    int npsel, npen, nbusy, noth, nacc, unstable, reads, run, c, n;
    logic pen_first, prev, started, fin, first;
    logic [31:0] paddr_s, pwdata_s;
    logic [65:0] snap, cur;
    int gaps[$];
    int done_base;

    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.clear_err = 1'b0;

    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_resetn = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // 1: WRITE conv, zero-wait slave
    q_exp.push_back(mk(K_WR, 2'd1, 32'h10, 32'hA5A5_0001, 2'd0));
    send_cmd({2'd0, 2'd1, 12'h010, 32'hA5A5_0001});
    drop_valid();
    npsel = 0; npen = 0; nbusy = 0; noth = 0; pen_first = 1'b1; paddr_s = '0; pwdata_s = '0;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge i_clk);
      if (bus.psel_conv) begin
        npsel++;
        if (npsel == 1) pen_first = bus.penable;
        paddr_s  = bus.paddr;
        pwdata_s = bus.pwdata;
      end
      npen  += int'(bus.penable);
      nbusy += int'(bus.busy);
      noth  += int'(bus.psel_fc | bus.psel_pool);
    end
    chk("wr_psel_cycles", 32'(npsel), 32'd2);
    chk("wr_penable_first", 32'(pen_first), 32'd0);
    chk("wr_penable_cycles", 32'(npen), 32'd1);
    chk("wr_busy_cycles", 32'(nbusy), 32'd3);
    chk("wr_other_psel", 32'(noth), 32'd0);
    chk("wr_paddr", paddr_s, 32'h10);
    chk("wr_pwdata", pwdata_s, 32'hA5A5_0001);
    chk("wr_ready_back", 32'(bus.cmd_ready), 32'd1);

    // 2: POLL pool, bit0 appears on the third read
    s_read_idx = 0; g_hit_read = 3; g_hit_val = 32'h1;
    repeat (3) q_exp.push_back(mk(K_RD, 2'd2, 32'h0, 32'h0, 2'd0));
    send_cmd({2'd1, 2'd2, 12'h000, 32'h1});
    drop_valid();
    prev = 1'b0; started = 1'b0; fin = 1'b0; reads = 0; run = 0; noth = 0;
    gaps.delete();
    for (int k = 1; (k <= 40) && !fin; k++) begin
      if (k > 1) @(negedge i_clk);
      if (bus.psel_pool) begin
        if (!prev) begin
          reads++;
          if (started) gaps.push_back(run);
          started = 1'b1;
        end
        run = 0;
      end else if (started) begin
        run++;
      end
      prev = bus.psel_pool;
      noth += int'(bus.psel_fc | bus.psel_conv);
      if (bus.cmd_ready) fin = 1'b1;
    end
    chk("poll_reads", 32'(reads), 32'd3);
    chk("poll_gap_count", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) chk("poll_gap_len", 32'(gaps[i]), 32'(GAP));
    chk("poll_other_psel", 32'(noth), 32'd0);
    chk("poll_finished", 32'(fin), 32'd1);

    // 3: POLL fc never satisfied -> timeout after 50 cycles. Reads start every
    // 6 cycles; the ninth is answered on the bus in the cycle the timeout fires.
    s_read_idx = 0; g_hit_read = 0;
    repeat (9) q_exp.push_back(mk(K_RD, 2'd0, 32'h4, 32'h0, 2'd0));
    q_exp.push_back(mk(K_ERR, 2'd0, 32'd0, 32'd0, 2'd2));
    send_cmd({2'd1, 2'd0, 12'h004, 32'h1});
    drop_valid();
    c = 1;
    while (!bus.err && (c < 120)) begin
      @(negedge i_clk);
      c++;
    end
    chk("tmo_cycles", 32'(c - 1), 32'(TMO));
    chk("tmo_code", 32'(bus.err_code), 32'd2);
    chk("tmo_busy", 32'(bus.busy), 32'd1);
    chk("tmo_bus_idle", 32'({bus.psel_fc, bus.psel_conv, bus.psel_pool, bus.penable, bus.cmd_ready}), 32'd0);
    pulse_clear();
    chk("tmo_cleared", 32'({bus.err, bus.err_code}), 32'd0);
    wait_ready("tmo_recover");

    // 4: WRITE fc, 3 wait states then PSLVERR
    g_wait = 3; g_err = 1'b1;
    q_exp.push_back(mk(K_WR, 2'd0, 32'h100, 32'hDEAD_BEEF, 2'd1));
    q_exp.push_back(mk(K_ERR, 2'd0, 32'd0, 32'd0, 2'd1));
    send_cmd({2'd0, 2'd0, 12'h100, 32'hDEAD_BEEF});
    drop_valid();
    nacc = 0; unstable = 0; first = 1'b1; snap = '0;
    for (int k = 1; (k <= 30) && !bus.err; k++) begin
      if (k > 1) @(negedge i_clk);
      if (bus.psel_fc && bus.penable) begin
        nacc++;
        cur = {bus.paddr, bus.pwdata, bus.pwrite, bus.psel_fc};
        if (first) snap = cur;
        else if (cur !== snap) unstable++;
        first = 1'b0;
      end
    end
    chk("slverr_access_cycles", 32'(nacc), 32'd4);
    chk("slverr_unstable", 32'(unstable), 32'd0);
    chk("slverr_err", 32'(bus.err), 32'd1);
    chk("slverr_code", 32'(bus.err_code), 32'd1);
    g_wait = 0; g_err = 1'b0;
    pulse_clear();
    wait_ready("slverr_recover");

    // 5: stream with CMD_VALID held, then illegal unit and illegal op
    s_read_idx = 0; g_hit_read = 1; g_hit_val = 32'h4;
    done_base = g_done_cnt;
    q_exp.push_back(mk(K_WR, 2'd2, 32'h20, 32'h1111_1111, 2'd0));
    q_exp.push_back(mk(K_WR, 2'd0, 32'h44, 32'h2222_2222, 2'd0));
    q_exp.push_back(mk(K_RD, 2'd1, 32'h8, 32'h0, 2'd0));
    q_exp.push_back(mk(K_DONE, 2'd0, 32'd0, 32'd0, 2'd0));
    send_cmd({2'd0, 2'd2, 12'h020, 32'h1111_1111});
    send_cmd({2'd0, 2'd0, 12'h044, 32'h2222_2222});
    send_cmd({2'd1, 2'd1, 12'h008, 32'h4});
    send_cmd({2'd2, 2'd0, 12'h000, 32'h0});
    drop_valid();
    repeat (3) @(negedge i_clk);
    chk("stream_done_pulses", 32'(g_done_cnt - done_base), 32'd1);
    chk("stream_idle", 32'(bus.busy), 32'd0);

    q_exp.push_back(mk(K_ERR, 2'd0, 32'd0, 32'd0, 2'd3));
    send_cmd({2'd0, 2'd3, 12'h010, 32'h5});
    drop_valid();
    noth = 0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) @(negedge i_clk);
      noth += int'(bus.psel_fc | bus.psel_conv | bus.psel_pool);
    end
    chk("bad_unit_code", 32'({bus.err, bus.err_code}), 32'h7);
    chk("bad_unit_no_psel", 32'(noth), 32'd0);
    pulse_clear();
    wait_ready("bad_unit_recover");

    q_exp.push_back(mk(K_ERR, 2'd0, 32'd0, 32'd0, 2'd3));
    send_cmd({2'd3, 2'd0, 12'h010, 32'h5});
    drop_valid();
    chk("bad_op_code", 32'({bus.err, bus.err_code}), 32'h7);
    pulse_clear();
    wait_ready("bad_op_recover");

    // 6: reset during ACCESS, then a fresh WRITE
    g_wait = 5;
    send_cmd({2'd0, 2'd1, 12'h030, 32'h0BAD_0BAD});
    drop_valid();
    n = 0;
    while (!bus.penable && (n < 20)) begin
      @(negedge i_clk);
      n++;
    end
    chk("abort_in_access", 32'(bus.penable & bus.psel_conv), 32'd1);
    i_resetn = 1'b0;
    @(negedge i_clk);
    chk_zero("abort");
    i_resetn = 1'b1;
    g_wait = 0;
    wait_ready("abort_recover");
    q_exp.push_back(mk(K_WR, 2'd1, 32'h34, 32'h1234_5678, 2'd0));
    send_cmd({2'd0, 2'd1, 12'h034, 32'h1234_5678});
    drop_valid();
    wait_ready("post_abort_write");

    repeat (5) @(negedge i_clk);
    chk("sb_drained", 32'(q_exp.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
